core_mem_arbiter: RTL and testbench

Shares one single-port synchronous RAM between three requesters: the core instruction-fetch port, the core data port and a UART program loader.
- Sits between the pipelined RV32I core and the shared RAM.
- Data accesses get priority; a starvation guard protects fetch.
- The loader can take exclusive ownership of the RAM to download a program while the core is held.

---
 rtl/core_mem_arbiter.sv | 153 +++++++++++++++
 tb/tb_core_mem_arbiter.sv | 327 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/core_mem_arbiter.sv
// core_mem_arbiter: shares one single-port RAM between core fetch, core data
// and a UART program loader that can take exclusive ownership of the RAM.
module core_mem_arbiter #(
    parameter int AW       = 14,
    parameter int MAX_WAIT = 3,
    parameter int CNT_W    = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             i_req,
    input  logic [AW-1:0]    i_addr,
    output logic             i_gnt,
    output logic             i_rvalid,
    output logic [31:0]      i_rdata,
    input  logic             d_req,
    input  logic [3:0]       d_wmask,
    input  logic [AW-1:0]    d_addr,
    input  logic [31:0]      d_wdata,
    output logic             d_gnt,
    output logic             d_rvalid,
    output logic [31:0]      d_rdata,
    input  logic             l_own,
    output logic             l_owned,
    input  logic             l_req,
    input  logic [AW-1:0]    l_addr,
    input  logic [31:0]      l_wdata,
    output logic             l_gnt,
    output logic [CNT_W-1:0] l_count,
    output logic             ram_en,
    output logic [3:0]       ram_wmask,
    output logic [AW-1:0]    ram_addr,
    output logic [31:0]      ram_wdata,
    input  logic [31:0]      ram_rdata
);

    typedef enum logic {
        ST_RUN  = 1'b0,
        ST_LOAD = 1'b1
    } state_t;

    localparam logic [3:0] WAIT_LIM = 4'(MAX_WAIT);

    state_t           state_q;
    state_t           state_d;
    logic [3:0]       wait_q;
    logic [CNT_W-1:0] cnt_q;
    logic             i_pend_q;
    logic             d_pend_q;
    logic             gi;
    logic             gd;
    logic             gl;

    // State register: RUN serves the core, LOAD belongs to the loader
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_RUN;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state simply follows the loader's ownership request
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_RUN:  if (l_own) state_d = ST_LOAD;
            ST_LOAD: if (!l_own) state_d = ST_RUN;
        endcase
    end

    // Grant decode: data first unless fetch has waited MAX_WAIT cycles
    always_comb begin
        gi = 1'b0;
        gd = 1'b0;
        gl = 1'b0;
        if (!reset) begin
            unique case (state_q)
                ST_RUN: begin
                    if (d_req && i_req) begin
                        if (wait_q == WAIT_LIM) gi = 1'b1;
                        else                    gd = 1'b1;
                    end else begin
                        gi = i_req;
                        gd = d_req;
                    end
                end
                ST_LOAD: gl = l_req && l_own;
            endcase
        end
    end

    // RAM port mux driven by whichever requester holds the grant
    always_comb begin
        ram_en    = gi | gd | gl;
        ram_wmask = 4'b0000;
        ram_addr  = i_addr;
        ram_wdata = d_wdata;
        if (gd) begin
            ram_wmask = d_wmask;
            ram_addr  = d_addr;
        end else if (gl) begin
            ram_wmask = 4'b1111;
            ram_addr  = l_addr;
            ram_wdata = l_wdata;
        end
    end

    // Starvation counter: consecutive cycles fetch was asked but denied
    always_ff @(posedge clk) begin
        if (reset) begin
            wait_q <= 4'd0;
        end else if (state_q == ST_LOAD || state_d == ST_LOAD) begin
            wait_q <= 4'd0;
        end else if (i_req && !gi) begin
            if (wait_q != WAIT_LIM) wait_q <= wait_q + 4'd1;
        end else begin
            wait_q <= 4'd0;
        end
    end

    // Loader word counter, restarted at the start of each session
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= '0;
        end else if (state_q == ST_RUN && l_own) begin
            cnt_q <= '0;
        end else if (gl) begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

    // Read tracking: RAM returns data one cycle after a read strobe
    always_ff @(posedge clk) begin
        if (reset) begin
            i_pend_q <= 1'b0;
            d_pend_q <= 1'b0;
        end else begin
            i_pend_q <= gi;
            d_pend_q <= gd && (d_wmask == 4'b0000);
        end
    end

    assign i_gnt    = gi;
    assign d_gnt    = gd;
    assign l_gnt    = gl;
    assign i_rvalid = i_pend_q;
    assign d_rvalid = d_pend_q;
    assign i_rdata  = ram_rdata;
    assign d_rdata  = ram_rdata;
    assign l_owned  = (state_q == ST_LOAD);
    assign l_count  = cnt_q;

endmodule

// File: tb/tb_core_mem_arbiter.sv
// tb_core_mem_arbiter: directed and random checks of core_mem_arbiter
// against a transaction-level model of the arbitration rules.
module tb_core_mem_arbiter;

    localparam int AW       = 14;
    localparam int MAX_WAIT = 3;
    localparam int CNT_W    = 16;
    localparam int DEPTH    = 1 << AW;

    logic             clk = 1'b0;
    logic             reset;
    logic             i_req;
    logic [AW-1:0]    i_addr;
    logic             i_gnt;
    logic             i_rvalid;
    logic [31:0]      i_rdata;
    logic             d_req;
    logic [3:0]       d_wmask;
    logic [AW-1:0]    d_addr;
    logic [31:0]      d_wdata;
    logic             d_gnt;
    logic             d_rvalid;
    logic [31:0]      d_rdata;
    logic             l_own;
    logic             l_owned;
    logic             l_req;
    logic [AW-1:0]    l_addr;
    logic [31:0]      l_wdata;
    logic             l_gnt;
    logic [CNT_W-1:0] l_count;
    logic             ram_en;
    logic [3:0]       ram_wmask;
    logic [AW-1:0]    ram_addr;
    logic [31:0]      ram_wdata;
    logic [31:0]      ram_rdata;

    logic             tb_init;
    logic [31:0]      ram [0:DEPTH-1];

    int total = 0;
    int bad   = 0;

    // reference model state
    logic [31:0] ref_mem [0:DEPTH-1];
    bit          m_owned;
    int          m_denied;
    int          m_count;
    bit          m_pi;
    bit          m_pd;
    logic [31:0] m_pi_data;
    logic [31:0] m_pd_data;
    logic        last_ig;
    logic        last_dg;
    logic        last_lg;
    logic [7:0]  pat;

    core_mem_arbiter #(
        .AW(AW),
        .MAX_WAIT(MAX_WAIT),
        .CNT_W(CNT_W)
    ) dut (
        .clk(clk),
        .reset(reset),
        .i_req(i_req),
        .i_addr(i_addr),
        .i_gnt(i_gnt),
        .i_rvalid(i_rvalid),
        .i_rdata(i_rdata),
        .d_req(d_req),
        .d_wmask(d_wmask),
        .d_addr(d_addr),
        .d_wdata(d_wdata),
        .d_gnt(d_gnt),
        .d_rvalid(d_rvalid),
        .d_rdata(d_rdata),
        .l_own(l_own),
        .l_owned(l_owned),
        .l_req(l_req),
        .l_addr(l_addr),
        .l_wdata(l_wdata),
        .l_gnt(l_gnt),
        .l_count(l_count),
        .ram_en(ram_en),
        .ram_wmask(ram_wmask),
        .ram_addr(ram_addr),
        .ram_wdata(ram_wdata),
        .ram_rdata(ram_rdata)
    );

    always #5 clk = ~clk;

    // Single-port synchronous RAM; rdata is garbage except after a read
    always @(posedge clk) begin
        if (tb_init) begin
            for (int k = 0; k < DEPTH; k++) ram[k] <= 32'(k + 256);
        end else if (ram_en && ram_wmask != 4'b0000) begin
            if (ram_wmask[0]) ram[ram_addr][7:0]   <= ram_wdata[7:0];
            if (ram_wmask[1]) ram[ram_addr][15:8]  <= ram_wdata[15:8];
            if (ram_wmask[2]) ram[ram_addr][23:16] <= ram_wdata[23:16];
            if (ram_wmask[3]) ram[ram_addr][31:24] <= ram_wdata[31:24];
        end
        if (ram_en && ram_wmask == 4'b0000) ram_rdata <= ram[ram_addr];
        else                                ram_rdata <= $urandom;
    end

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock cycle: check outputs mid-cycle, then advance the model
    task automatic cyc();
        logic eig;
        logic edg;
        logic elg;
        logic een;
        logic [3:0] ew;
        logic [AW-1:0] ea;
        logic [31:0] ed;
        @(negedge clk);
        eig = 1'b0;
        edg = 1'b0;
        elg = 1'b0;
        if (!reset) begin
            if (!m_owned) begin
                if (d_req && (!i_req || m_denied < MAX_WAIT)) edg = 1'b1;
                else if (i_req)                              eig = 1'b1;
            end else begin
                elg = l_req && l_own;
            end
        end
        een = eig | edg | elg;
        ew  = edg ? d_wmask : (elg ? 4'hf : 4'h0);
        ea  = edg ? d_addr : (elg ? l_addr : i_addr);
        ed  = edg ? d_wdata : l_wdata;
        chk("i_gnt", 64'(i_gnt), 64'(eig));
        chk("d_gnt", 64'(d_gnt), 64'(edg));
        chk("l_gnt", 64'(l_gnt), 64'(elg));
        chk("ram_en", 64'(ram_en), 64'(een));
        if (een) begin
            chk("ram_addr", 64'(ram_addr), 64'(ea));
            chk("ram_wmask", 64'(ram_wmask), 64'(ew));
            if (ew != 4'h0) chk("ram_wdata", 64'(ram_wdata), 64'(ed));
        end
        chk("i_rvalid", 64'(i_rvalid), 64'(m_pi));
        chk("d_rvalid", 64'(d_rvalid), 64'(m_pd));
        if (m_pi) chk("i_rdata", 64'(i_rdata), 64'(m_pi_data));
        if (m_pd) chk("d_rdata", 64'(d_rdata), 64'(m_pd_data));
        chk("l_owned", 64'(l_owned), 64'(m_owned));
        chk("l_count", 64'(l_count), 64'(m_count));
        last_ig = i_gnt;
        last_dg = d_gnt;
        last_lg = l_gnt;
        @(posedge clk);
        if (reset) begin
            m_owned  = 1'b0;
            m_denied = 0;
            m_count  = 0;
            m_pi     = 1'b0;
            m_pd     = 1'b0;
        end else begin
            m_pi = eig;
            if (eig) m_pi_data = ref_mem[i_addr];
            m_pd = edg && (d_wmask == 4'h0);
            if (m_pd) m_pd_data = ref_mem[d_addr];
            if (edg && d_wmask != 4'h0) begin
                for (int b = 0; b < 4; b++)
                    if (d_wmask[b])
                        ref_mem[d_addr][8*b +: 8] = d_wdata[8*b +: 8];
            end
            if (elg) ref_mem[l_addr] = l_wdata;
            if (!m_owned) begin
                if (i_req && !eig)
                    m_denied = (m_denied < MAX_WAIT) ? m_denied + 1 : MAX_WAIT;
                else
                    m_denied = 0;
                if (l_own) m_count = 0;
            end else begin
                m_denied = 0;
                if (elg) m_count = (m_count + 1) % (1 << CNT_W);
            end
            m_owned = l_own;
        end
        #1;
    endtask

    initial begin
        for (int k = 0; k < DEPTH; k++) ref_mem[k] = 32'(k + 256);
        m_owned = 0; m_denied = 0; m_count = 0; m_pi = 0; m_pd = 0;
        m_pi_data = '0; m_pd_data = '0;
        last_ig = 0; last_dg = 0; last_lg = 0; pat = '0;
        reset = 1; tb_init = 1;
        i_req = 0; i_addr = '0;
        d_req = 0; d_wmask = '0; d_addr = '0; d_wdata = '0;
        l_own = 0; l_req = 0; l_addr = '0; l_wdata = '0;
        @(posedge clk);
        #1;
        tb_init = 0;
        i_req = 1; d_req = 1;
        cyc();
        i_req = 0; d_req = 0;
        reset = 0;
        chk("rst_l_owned", 64'(l_owned), 64'd0);
        chk("rst_l_count", 64'(l_count), 64'd0);
        chk("rst_i_rvalid", 64'(i_rvalid), 64'd0);

        // fetch-only reads
        for (int k = 0; k < 3; k++) begin
            i_req = 1; i_addr = AW'(k);
            cyc();
            chk("fetch_gnt", 64'(last_ig), 64'd1);
        end
        chk("fetch2_data", 64'(i_rdata), 64'h102);
        chk("fetch2_dvalid", 64'(d_rvalid), 64'd0);
        i_req = 0;
        cyc();

        // partial data write then readback
        d_req = 1; d_wmask = 4'b0011; d_addr = AW'(5);
        d_wdata = 32'hAABB_CCDD;
        cyc();
        chk("wr_no_rvalid", 64'(d_rvalid), 64'd0);
        d_wmask = 4'b0000;
        cyc();
        chk("rd5_valid", 64'(d_rvalid), 64'd1);
        chk("rd5_data", 64'(d_rdata), 64'h0000_CCDD);
        d_req = 0;
        cyc();

        // contention: fetch wins every MAX_WAIT+1 cycles
        d_req = 1; d_wmask = 4'b0000; d_addr = AW'(7);
        i_req = 1; i_addr = AW'(9);
        for (int k = 0; k < 8; k++) begin
            cyc();
            pat[k] = last_ig;
        end
        chk("starve_pat", 64'(pat), 64'h88);
        d_req = 0; i_req = 0;
        cyc();

        // fetch granted in the cycle ownership is requested
        i_req = 1; i_addr = AW'(3); l_own = 1;
        cyc();
        chk("own_fetch_gnt", 64'(last_ig), 64'd1);
        chk("own_owned", 64'(l_owned), 64'd1);
        chk("own_rvalid", 64'(i_rvalid), 64'd1);
        chk("own_rdata", 64'(i_rdata), 64'h103);
        d_req = 1; d_addr = AW'(4);
        for (int k = 0; k < 4; k++) begin
            l_req = 1; l_addr = AW'(16 + k); l_wdata = 32'hC0DE_0000 + k;
            cyc();
            chk("load_gnt", 64'(last_lg), 64'd1);
        end
        chk("load_count4", 64'(l_count), 64'd4);

        // release ownership with a loader request still up
        l_own = 0; l_addr = AW'(20);
        cyc();
        chk("release_lgnt", 64'(last_lg), 64'd0);
        l_req = 0; d_req = 0; i_req = 1; i_addr = AW'(16);
        cyc();
        chk("back_fetch", 64'(last_ig), 64'd1);
        chk("count_hold", 64'(l_count), 64'd4);
        chk("loaded_word", 64'(i_rdata), 64'hC0DE_0000);
        i_req = 0;
        cyc();

        // reset in LOAD with a nonzero word count
        l_own = 1;
        cyc();
        l_req = 1; l_addr = AW'(32); l_wdata = 32'h1234_5678;
        cyc();
        cyc();
        reset = 1;
        cyc();
        reset = 0; l_own = 0; l_req = 0;
        chk("rst_load_owned", 64'(l_owned), 64'd0);
        chk("rst_load_count", 64'(l_count), 64'd0);

        // reset while the last RUN-cycle read is outstanding
        i_req = 1; i_addr = AW'(2); l_own = 1;
        cyc();
        reset = 1; i_req = 0;
        cyc();
        i_req = 1; d_req = 1;
        #1;
        chk("rst_pend_irv", 64'(i_rvalid), 64'd0);
        chk("rst_pend_drv", 64'(d_rvalid), 64'd0);
        chk("rst_pend_own", 64'(l_owned), 64'd0);
        chk("rst_pend_cnt", 64'(l_count), 64'd0);
        chk("rst_pend_ignt", 64'(i_gnt), 64'd0);
        chk("rst_pend_dgnt", 64'(d_gnt), 64'd0);
        cyc();
        reset = 0; l_own = 0; i_req = 0; d_req = 0;
        cyc();

        // random traffic; requesters hold payload until granted
        for (int n = 0; n < 600; n++) begin
            if (!i_req || last_ig) begin
                i_req  = ($urandom_range(0, 2) != 0);
                i_addr = AW'($urandom_range(0, 63));
            end
            if (!d_req || last_dg) begin
                d_req   = ($urandom_range(0, 2) != 0);
                d_addr  = AW'($urandom_range(0, 63));
                d_wmask = ($urandom_range(0, 1) != 0) ? 4'($urandom) : 4'h0;
                d_wdata = $urandom;
            end
            if (!l_req || last_lg) begin
                l_req   = ($urandom_range(0, 1) != 0);
                l_addr  = AW'($urandom_range(0, 63));
                l_wdata = $urandom;
            end
            if ($urandom_range(0, 19) == 0) l_own = !l_own;
            reset = ($urandom_range(0, 99) == 0);
            cyc();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
